mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified instruction/data block RAM between the IF fetch requester and the MEM-stage load/store requester.
//  - Grants one request per cycle and drives the RAM port.
//  - Performs byte-lane steering: write byte enables, load extraction and sign extension.
//  - Returns responses after a fixed 1-cycle latency.
//  - Sits between the pipeline (IF, MEM) and the BRAM wrapper; core stall logic uses the grants.
// PARAMETERS
//  ADDR_W          13  RAM word-address width (8192 x 32b); byte-address bits [ADDR_W+1:2] used, upper bits ignored
//  MAX_DATA_BURST   4  consecutive data grants allowed while fetch waits before fetch is forced (>=1)
// PORTS
//  i_clk        in   1       clock, all state on posedge
//  i_reset      in   1       asynchronous, active-high reset
//  i_ifReq      in   1       fetch request
//  i_ifAddr     in   32      fetch byte address (word aligned, bits [1:0] ignored)
//  o_ifGnt      out  1       fetch granted this cycle (combinational)
//  o_ifValid    out  1       fetch response valid (registered)
//  o_ifInstr    out  32      fetched word, valid with o_ifValid
//  i_dReq       in   1       data request
//  i_dAddr      in   32      data byte address
//  i_dCtrl      in   mem_ctrl_t  memRead/memWrite/size/sign; sign=0 sign-extend, 1 zero-extend
//  i_dWdata     in   32      store data, LSB-justified
//  o_dGnt       out  1       data granted this cycle (combinational)
//  o_dValid     out  1       data response valid (loads and stores)
//  o_dRdata     out  32      formatted load data; 0 for stores/errors
//  o_dErr       out  1       misaligned or illegal-size access, valid with o_dValid
//  o_memEn      out  1       RAM port enable
//  o_memWe      out  4       RAM byte write enables
//  o_memAddr    out  ADDR_W  RAM word address
//  o_memWdata   out  32      RAM write data, lane-steered
//  i_memRdata   in   32      RAM read data, 1 cycle after o_memEn
// BEHAVIOUR
//  Reset: o_ifValid, o_dValid, o_dErr and burst counter are 0; in-flight responses are dropped immediately.
//    While i_reset=1, o_ifGnt, o_dGnt, o_memEn and o_memWe are forced 0.
//  Grant in cycle T:
//    - Only requester -> granted.
//    - Both requesting -> data wins, unless burstCnt==MAX_DATA_BURST, then fetch wins.
//    - Requester holds its request until granted; requests are stable while ungranted.
//  Burst counter:
//    - +1 on each data grant while i_ifReq=1, saturating at MAX_DATA_BURST.
//    - Cleared on any fetch grant, or any cycle with i_ifReq=0.
//  FSM (owner register) {IDLE, RESP_IF, RESP_D, RESP_DERR}: next state is set from the grant in T.
//    - Responses are in T+1: o_*Valid=1 in state RESP_*, then IDLE unless a new grant occurs.
//    - Back-to-back grants give one response per cycle, no bubbles.
//  Fetch grant: o_memEn=1, o_memWe=0, o_memAddr=i_ifAddr[ADDR_W+1:2].
//    - T+1: o_ifInstr=i_memRdata.
//  Data grant, legal:
//    - size 00: any address.
//    - size 01: addr[0]=0.
//    - size 10: addr[1:0]=0.
//    - o_memEn=1 for reads and writes.
//  Stores:
//    - o_memWe = 0001<<a[1:0] (byte), 0011<<{a[1],0} (half), 1111 (word).
//    - o_memWdata replicates the byte/half across lanes.
//    - T+1: o_dValid=1, o_dRdata=0.
//  Loads: lane and byte offset are registered at T.
//    - T+1: extract from i_memRdata at the registered offset.
//    - Sign/zero-extend per sign: sign=0 sign-extends, sign=1 zero-extends.
//  Neither memRead nor memWrite set: treated as no request (no grant).
//  Illegal access (misaligned, or size 11):
//    - Granted, but o_memEn=0, o_memWe=0.
//    - T+1: o_dValid=1, o_dErr=1, o_dRdata=0.
//  memRead and memWrite both set: write takes effect; the response is a store ack.
//  Outputs are Xs-free: o_ifInstr/o_dRdata are 0 when the matching valid is 0.
// STRUCTURE
//  Package mem_pkg:
//    - mem_ctrl_t (existing) and arb_state_t enum.
//    - Constants SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10.
//  Sub-module mem_lane_fmt (combinational), two functions:
//    - store steer: size, a[1:0], wdata -> we, wdata.
//    - load extract: size, a[1:0], sign, rdata -> rdata.
//  Top holds the grant logic, burst counter, owner FSM and response registers.
// TESTING
//  1. Fetch only, 0x0,0x4,0x8 back-to-back -> o_ifGnt each cycle, o_ifValid T+1, o_ifInstr = RAM words 0,1,2.
//  2. Store word 0x8000_00F1 @0x100, then LB/LBU @0x100..0x103.
//     - Store: o_memWe=1111.
//     - LB returns 0xFFFF_FFF1, 0, 0, 0xFFFF_FF80.
//     - LBU @0x103 returns 0x80.
//  3. SH 0xBEEF @0x202 -> o_memWe=1100, o_memWdata=0xBEEF_BEEF.
//     - LH @0x202 -> 0xFFFF_BEEF; LHU -> 0x0000_BEEF.
//  4. Fetch and data requesting continuously, MAX_DATA_BURST=4.
//     - Grant pattern D,D,D,D,F repeating; counter clears on F.
//  5. LW @0x102, LH @0x301, size 11.
//     - Each: o_memEn=0, o_dValid=1 with o_dErr=1, o_dRdata=0.
//     - RAM contents unchanged.
//  6. Assert i_reset between a grant and its response.
//     - o_ifValid/o_dValid drop 0 asynchronously; no response after release.
//     - The first grant after release is served normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the unified instruction/data memory port.
package mem_pkg;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic [1:0] size;
    logic       sign;     // 0 = sign-extend, 1 = zero-extend
  } mem_ctrl_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP_IF   = 2'd1,
    RESP_D    = 2'd2,
    RESP_DERR = 2'd3
  } arb_state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane steering: store enables/replication and load
// extraction with sign or zero extension.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_we,
  output logic [31:0] o_st_wdata,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_sign,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  function automatic logic [35:0] store_steer(input logic [1:0] size,
                                              input logic [1:0] off,
                                              input logic [31:0] wd);
    logic [3:0] be_b;
    logic [3:0] be_h;
    be_b = 4'b0001 << off;
    be_h = 4'b0011 << {off[1], 1'b0};
    case (size)
      SIZE_B:  return {be_b, {4{wd[7:0]}}};
      SIZE_H:  return {be_h, {2{wd[15:0]}}};
      SIZE_W:  return {4'b1111, wd};
      default: return 36'h0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size,
                                               input logic [1:0] off,
                                               input logic sign,
                                               input logic [31:0] rd);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    sh_b = rd >> {off, 3'b000};
    sh_h = rd >> {off[1], 4'b0000};
    case (size)
      SIZE_B:  return sign ? {24'h0, sh_b[7:0]} : {{24{sh_b[7]}}, sh_b[7:0]};
      SIZE_H:  return sign ? {16'h0, sh_h[15:0]} : {{16{sh_h[15]}}, sh_h[15:0]};
      SIZE_W:  return rd;
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    {o_st_we, o_st_wdata} = store_steer(i_st_size, i_st_off, i_st_wdata);
    o_ld_data = load_extract(i_ld_size, i_ld_off, i_ld_sign, i_ld_rdata);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single BRAM port between instruction fetch and load/store,
// with a burst limit that guarantees fetch progress and 1-cycle responses.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 13,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ifReq,
  input  logic [31:0]       i_ifAddr,
  output logic              o_ifGnt,
  output logic              o_ifValid,
  output logic [31:0]       o_ifInstr,
  input  logic              i_dReq,
  input  logic [31:0]       i_dAddr,
  input  mem_ctrl_t         i_dCtrl,
  input  logic [31:0]       i_dWdata,
  output logic              o_dGnt,
  output logic              o_dValid,
  output logic [31:0]       o_dRdata,
  output logic              o_dErr,
  output logic              o_memEn,
  output logic [3:0]        o_memWe,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [31:0]       o_memWdata,
  input  logic [31:0]       i_memRdata
);

  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

  arb_state_t    state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [1:0]    ld_size_q, ld_size_d;
  logic [1:0]    ld_off_q, ld_off_d;
  logic          ld_sign_q, ld_sign_d;
  logic          ld_load_q, ld_load_d;

  logic        d_act, d_legal, d_access, if_gnt, d_gnt;
  logic [3:0]  st_we;
  logic [31:0] st_wdata, ld_data;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{i_ifAddr[31:ADDR_W+2], i_ifAddr[1:0], i_dAddr[31:ADDR_W+2]};

  // A data request with neither read nor write set is not a request at all.
  assign d_act = i_dReq & (i_dCtrl.memRead | i_dCtrl.memWrite);

  always_comb begin
    case (i_dCtrl.size)
      SIZE_B:  d_legal = 1'b1;
      SIZE_H:  d_legal = ~i_dAddr[0];
      SIZE_W:  d_legal = (i_dAddr[1:0] == 2'b00);
      default: d_legal = 1'b0;
    endcase
  end

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!i_reset) begin
      if (d_act && !(i_ifReq && burst_q == BURST_MAX)) d_gnt = 1'b1;
      else if (i_ifReq)                                 if_gnt = 1'b1;
    end
  end

  assign d_access = d_gnt & d_legal;

  mem_lane_fmt u_fmt (
    .i_st_size  (i_dCtrl.size),
    .i_st_off   (i_dAddr[1:0]),
    .i_st_wdata (i_dWdata),
    .o_st_we    (st_we),
    .o_st_wdata (st_wdata),
    .i_ld_size  (ld_size_q),
    .i_ld_off   (ld_off_q),
    .i_ld_sign  (ld_sign_q),
    .i_ld_rdata (i_memRdata),
    .o_ld_data  (ld_data)
  );

  assign o_ifGnt    = if_gnt;
  assign o_dGnt     = d_gnt;
  assign o_memEn    = if_gnt | d_access;
  assign o_memWe    = (d_access && i_dCtrl.memWrite) ? st_we : 4'b0000;
  assign o_memAddr  = if_gnt ? i_ifAddr[ADDR_W+1:2] : i_dAddr[ADDR_W+1:2];
  assign o_memWdata = st_wdata;

  always_comb begin
    state_d   = IDLE;
    burst_d   = burst_q;
    ld_size_d = ld_size_q;
    ld_off_d  = ld_off_q;
    ld_sign_d = ld_sign_q;
    ld_load_d = ld_load_q;
    if (if_gnt) begin
      state_d = RESP_IF;
    end else if (d_gnt) begin
      state_d   = d_legal ? RESP_D : RESP_DERR;
      ld_size_d = i_dCtrl.size;
      ld_off_d  = i_dAddr[1:0];
      ld_sign_d = i_dCtrl.sign;
      // Read+write together is a store; only pure reads return data.
      ld_load_d = i_dCtrl.memRead & ~i_dCtrl.memWrite;
    end
    if (!i_ifReq || if_gnt)               burst_d = '0;
    else if (d_gnt && burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      ld_size_q <= 2'b00;
      ld_off_q  <= 2'b00;
      ld_sign_q <= 1'b0;
      ld_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      ld_size_q <= ld_size_d;
      ld_off_q  <= ld_off_d;
      ld_sign_q <= ld_sign_d;
      ld_load_q <= ld_load_d;
    end
  end

  assign o_ifValid = (state_q == RESP_IF);
  assign o_ifInstr = (state_q == RESP_IF) ? i_memRdata : 32'h0;
  assign o_dValid  = (state_q == RESP_D) || (state_q == RESP_DERR);
  assign o_dErr    = (state_q == RESP_DERR);
  assign o_dRdata  = (state_q == RESP_D && ld_load_q) ? ld_data : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a behavioural BRAM.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_ifReq;
  logic [31:0] i_ifAddr;
  logic        o_ifGnt, o_ifValid;
  logic [31:0] o_ifInstr;
  logic        i_dReq;
  logic [31:0] i_dAddr;
  mem_ctrl_t   i_dCtrl;
  logic [31:0] i_dWdata;
  logic        o_dGnt, o_dValid, o_dErr;
  logic [31:0] o_dRdata;
  logic        o_memEn;
  logic [3:0]  o_memWe;
  logic [12:0] o_memAddr;
  logic [31:0] o_memWdata;
  logic [31:0] i_memRdata;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] ifq[$];
  logic [32:0] dq[$];   // {err, rdata}
  logic [31:0] ram [0:8191];

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(.ADDR_W(13), .MAX_DATA_BURST(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_ifReq(i_ifReq), .i_ifAddr(i_ifAddr), .o_ifGnt(o_ifGnt),
    .o_ifValid(o_ifValid), .o_ifInstr(o_ifInstr),
    .i_dReq(i_dReq), .i_dAddr(i_dAddr), .i_dCtrl(i_dCtrl), .i_dWdata(i_dWdata),
    .o_dGnt(o_dGnt), .o_dValid(o_dValid), .o_dRdata(o_dRdata), .o_dErr(o_dErr),
    .o_memEn(o_memEn), .o_memWe(o_memWe), .o_memAddr(o_memAddr),
    .o_memWdata(o_memWdata), .i_memRdata(i_memRdata)
  );

  // Behavioural single-port BRAM, registered read.
  always @(posedge i_clk) begin
    if (o_memEn) begin
      i_memRdata <= ram[o_memAddr];
      for (int b = 0; b < 4; b++)
        if (o_memWe[b]) ram[o_memAddr][8*b +: 8] <= o_memWdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_ifValid) begin
        chk("if_resp_expected", ifq.size() != 0, 1);
        if (ifq.size() != 0) chk("if_instr", o_ifInstr, ifq.pop_front());
        $display("if resp instr=%h", o_ifInstr);
      end else begin
        chk("if_instr_idle0", o_ifInstr, 0);
      end
      if (o_dValid) begin
        logic [32:0] e;
        chk("d_resp_expected", dq.size() != 0, 1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          chk("d_rdata", o_dRdata, e[31:0]);
          chk("d_err", o_dErr, e[32]);
        end
        $display("d  resp rdata=%h err=%0b", o_dRdata, o_dErr);
      end else begin
        chk("d_rdata_idle0", o_dRdata, 0);
      end
    end
  end

  task automatic f_op(input logic [31:0] addr, input logic [31:0] exp);
    i_ifReq = 1'b1; i_ifAddr = addr; i_dReq = 1'b0;
    #2;
    chk("if_gnt", o_ifGnt, 1);
    chk("if_memEn", o_memEn, 1);
    chk("if_memWe", o_memWe, 0);
    chk("if_memAddr", o_memAddr, addr[14:2]);
    ifq.push_back(exp);
    @(posedge i_clk); #1;
  endtask

  task automatic d_op(input logic [31:0] addr, input logic rd, input logic wr,
                      input logic [1:0] sz, input logic sg, input logic [31:0] wd,
                      input logic exp_en, input logic [3:0] exp_we, input logic [31:0] exp_wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    i_ifReq = 1'b0; i_dReq = 1'b1; i_dAddr = addr; i_dWdata = wd;
    i_dCtrl = '{memRead: rd, memWrite: wr, size: sz, sign: sg};
    #2;
    chk("d_gnt", o_dGnt, 1);
    chk("d_memEn", o_memEn, exp_en);
    chk("d_memWe", o_memWe, exp_we);
    if (exp_we != 4'b0000) chk("d_memWdata", o_memWdata, exp_wd);
    dq.push_back({exp_err, exp_rd});
    @(posedge i_clk); #1;
  endtask

  task automatic idle(input int n);
    i_ifReq = 1'b0; i_dReq = 1'b0;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 32'h0;
    ram[0] = 32'h1111_1111; ram[1] = 32'h2222_2222; ram[2] = 32'h3333_3333;
    ram[13'h0C0] = 32'h1234_5678;
    i_reset = 1'b1; i_ifReq = 1'b0; i_ifAddr = 32'h0; i_dReq = 1'b0;
    i_dAddr = 32'h0; i_dCtrl = '0; i_dWdata = 32'h0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ifValid", o_ifValid, 0);
    chk("rst_dValid", o_dValid, 0);
    chk("rst_dErr", o_dErr, 0);
    chk("rst_memEn", o_memEn, 0);
    #2 i_reset = 1'b0;
    @(posedge i_clk); #1;

    // 1: back-to-back fetches
    f_op(32'h0, 32'h1111_1111);
    f_op(32'h4, 32'h2222_2222);
    f_op(32'h8, 32'h3333_3333);
    idle(2);

    // 2: SW then LB/LBU
    d_op(32'h100, 0, 1, SIZE_W, 0, 32'h8000_00F1, 1, 4'b1111, 32'h8000_00F1, 0, 0);
    d_op(32'h100, 1, 0, SIZE_B, 0, 0, 1, 4'b0000, 0, 32'hFFFF_FFF1, 0);
    d_op(32'h101, 1, 0, SIZE_B, 0, 0, 1, 4'b0000, 0, 32'h0, 0);
    d_op(32'h102, 1, 0, SIZE_B, 0, 0, 1, 4'b0000, 0, 32'h0, 0);
    d_op(32'h103, 1, 0, SIZE_B, 0, 0, 1, 4'b0000, 0, 32'hFFFF_FF80, 0);
    d_op(32'h103, 1, 0, SIZE_B, 1, 0, 1, 4'b0000, 0, 32'h0000_0080, 0);
    idle(1);

    // 3: SH then LH/LHU
    d_op(32'h202, 0, 1, SIZE_H, 0, 32'h0000_BEEF, 1, 4'b1100, 32'hBEEF_BEEF, 0, 0);
    d_op(32'h202, 1, 0, SIZE_H, 0, 0, 1, 4'b0000, 0, 32'hFFFF_BEEF, 0);
    d_op(32'h202, 1, 0, SIZE_H, 1, 0, 1, 4'b0000, 0, 32'h0000_BEEF, 0);
    // read+write together acts as a store
    d_op(32'h201, 1, 1, SIZE_B, 0, 32'h0000_00A5, 1, 4'b0010, 32'hA5A5_A5A5, 0, 0);
    idle(1);

    // neither read nor write: no grant
    i_dReq = 1'b1; i_dAddr = 32'h100; i_dCtrl = '0;
    #2;
    chk("noop_dGnt", o_dGnt, 0);
    chk("noop_memEn", o_memEn, 0);
    @(posedge i_clk); #1;
    idle(1);

    // 4: continuous contention, expect D,D,D,D,F repeating
    for (int k = 0; k < 10; k++) begin
      logic exp_d;
      i_ifReq = 1'b1; i_ifAddr = 32'h0;
      i_dReq = 1'b1; i_dAddr = 32'h100;
      i_dCtrl = '{memRead: 1'b1, memWrite: 1'b0, size: SIZE_W, sign: 1'b0};
      exp_d = (k % 5) != 4;
      #2;
      chk($sformatf("burst_dGnt_%0d", k), o_dGnt, exp_d);
      chk($sformatf("burst_ifGnt_%0d", k), o_ifGnt, !exp_d);
      if (exp_d) dq.push_back({1'b0, 32'h8000_00F1});
      else       ifq.push_back(32'h1111_1111);
      @(posedge i_clk); #1;
    end
    idle(1);

    // 5: illegal accesses, RAM must stay unchanged
    d_op(32'h102, 1, 0, SIZE_W, 0, 0, 0, 4'b0000, 0, 0, 1);
    d_op(32'h301, 0, 1, SIZE_H, 0, 32'hFFFF_FFFF, 0, 4'b0000, 0, 0, 1);
    d_op(32'h300, 0, 1, 2'b11, 0, 32'hFFFF_FFFF, 0, 4'b0000, 0, 0, 1);
    d_op(32'h300, 1, 0, SIZE_W, 0, 0, 1, 4'b0000, 0, 32'h1234_5678, 0);
    d_op(32'h200, 1, 0, SIZE_W, 0, 0, 1, 4'b0000, 0, 32'hBEEF_A500, 0);
    idle(1);

    // 6: reset between grant and response
    f_op(32'h4, 32'h2222_2222);
    d_op(32'h100, 1, 0, SIZE_W, 0, 0, 1, 4'b0000, 0, 32'h8000_00F1, 0);
    i_dReq = 1'b0; i_ifReq = 1'b1; i_ifAddr = 32'h8;
    #1 i_reset = 1'b1;
    #1;
    chk("rst_drop_dValid", o_dValid, 0);
    chk("rst_drop_ifValid", o_ifValid, 0);
    chk("rst_ifGnt", o_ifGnt, 0);
    chk("rst_memEn_hold", o_memEn, 0);
    dq.delete();
    ifq.delete();
    @(posedge i_clk); @(posedge i_clk);
    #2 i_reset = 1'b0;
    #1;
    chk("post_rst_ifGnt", o_ifGnt, 1);
    ifq.push_back(32'h3333_3333);
    @(posedge i_clk); #1;
    idle(3);

    chk("ifq_drained", ifq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
